// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of the hazard-control signals exchanged between the pipeline
// datapath (master) and the hazard controller (slave). The master drives
// the decoded register specifiers and status bits; the slave returns the
// latch enables, flush/bubble controls, debug state and statistics.
// The controls are level signals sampled every cycle: there is no
// valid/ready pair, the datapath simply obeys whatever the controller
// presents in the same cycle.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 16
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  branch_taken;
  logic                  imem_ready;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic [1:0]            ctrl_state;
  logic [STAT_W-1:0]     stall_count;
  logic [STAT_W-1:0]     flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken, imem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken, imem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the PC and IF/ID latch of a 5-stage MIPS pipeline.
// Handles load-use stalls, taken-branch flushes (BRANCH_PENALTY cycles) and
// instruction-memory wait states. Outputs are Mealy: combinational from the
// FSM state and the current inputs.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush counters;
// without it stall_count and flush_count are tied to zero.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int BRANCH_PENALTY = 1,
  parameter int STAT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [2:0] PEN_M1  = 3'(BRANCH_PENALTY - 1);
  localparam bit         MULTI   = (BRANCH_PENALTY > 1);

  logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rt;
  logic [1:0]            state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic                  load_use;
  logic                  pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic                  branch_flush;
  logic [STAT_W-1:0]     stall_q, flush_q;

  assign id_rs = hz.id_rs;
  assign id_rt = hz.id_rt;
  assign ex_rt = hz.ex_rt;

  // A load in EX whose destination (other than $zero) is read by the ID instruction.
  assign load_use = hz.ex_mem_read && (ex_rt != '0) &&
                    ((hz.id_uses_rs && (id_rs == ex_rt)) ||
                     (hz.id_uses_rt && (id_rt == ex_rt)));

  // Next-state and Mealy control outputs; branch beats load-use beats imem wait.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    branch_flush = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nxt    = S_RUN;
      cnt_nxt      = '0;
    end else begin
      case (state)
        S_FLUSH: begin
          // Squashed slot: branch and load-use in this cycle are ignored.
          pc_write     = 1'b1;
          if_id_flush  = 1'b1;
          branch_flush = 1'b1;
          cnt_nxt      = cnt - 3'd1;
          if (cnt <= 3'd1) state_nxt = S_RUN;
        end
        S_WAIT: begin
          if (hz.branch_taken) begin
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            branch_flush = 1'b1;
            cnt_nxt      = PEN_M1;
            if (MULTI)               state_nxt = S_FLUSH;
            else if (hz.imem_ready)  state_nxt = S_RUN;
            else                     state_nxt = S_WAIT;
          end else if (hz.imem_ready) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            state_nxt   = S_RUN;
          end else begin
            if_id_flush = 1'b1;
          end
        end
        default: begin
          // RUN, and the illegal encoding which falls back to RUN.
          state_nxt = S_RUN;
          if (hz.branch_taken) begin
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            branch_flush = 1'b1;
            cnt_nxt      = PEN_M1;
            if (MULTI) state_nxt = S_FLUSH;
          end else if (load_use) begin
            id_ex_bubble = 1'b1;
          end else if (!hz.imem_ready) begin
            if_id_flush = 1'b1;
            state_nxt   = S_WAIT;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
      endcase
    end
  end

  // FSM state and remaining-flush counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating counts of stall cycles (pc_write low) and branch-caused flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1))    stall_q <= stall_q + STAT_W'(1);
      if (branch_flush && (flush_q != '1)) flush_q <= flush_q + STAT_W'(1);
    end
  end
`else
  assign stall_q = '0;
  assign flush_q = '0;
`endif

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.ctrl_state   = state;
  assign hz.stall_count  = stall_q;
  assign hz.flush_count  = flush_q;
endmodule
